// File: rtl/cmpl_arbiter.sv
// Completion-bus arbiter: one-entry holding slot per functional unit, rotating-priority grant
// of up to NUM_PORTS slots per cycle onto registered ROB completion ports. Optional CMPL_ARB_STAT_EN.
module cmpl_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 4,
  parameter int XLEN      = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      cmp_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*XLEN-1:0]   req_pc,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]      cmp_valid,
  output logic [NUM_PORTS*XLEN-1:0] cmp_pc,
  output logic [NUM_PORTS*XLEN-1:0] cmp_data
`ifdef CMPL_ARB_STAT_EN
  ,
  output logic [15:0]               arb_conflict_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_PORTS + 1);
  localparam logic [IDX_W:0]   NREQ   = (IDX_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] NPORTS = CNT_W'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]   slot_valid_reg;
  logic [XLEN-1:0]      slot_pc_reg   [NUM_REQ];
  logic [XLEN-1:0]      slot_data_reg [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     rr_ptr_next;

  logic [NUM_PORTS-1:0] cmp_valid_reg;
  logic [XLEN-1:0]      cmp_pc_reg   [NUM_PORTS];
  logic [XLEN-1:0]      cmp_data_reg [NUM_PORTS];

  logic [XLEN-1:0]      req_pc_arr   [NUM_REQ];
  logic [XLEN-1:0]      req_data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]   grant;
  logic [NUM_PORTS-1:0] port_vld;
  logic [IDX_W-1:0]     port_idx [NUM_PORTS];
  logic [IDX_W-1:0]     last_idx;
  logic [CNT_W-1:0]     grant_cnt;
  logic [IDX_W:0]       scan_sum;
  logic [IDX_W-1:0]     scan_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
      assign req_pc_arr[gi]   = req_pc[gi*XLEN +: XLEN];
      assign req_data_arr[gi] = req_data[gi*XLEN +: XLEN];
    end
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_pack
      assign cmp_pc[gi*XLEN +: XLEN]   = cmp_pc_reg[gi];
      assign cmp_data[gi*XLEN +: XLEN] = cmp_data_reg[gi];
    end
  endgenerate

  assign cmp_valid = cmp_valid_reg;

  // Scan from rr_ptr with wrap; the n-th valid slot found lands on port n.
  always_comb begin
    grant     = '0;
    port_vld  = '0;
    last_idx  = '0;
    grant_cnt = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) port_idx[k] = '0;
    if (!cmp_hold && !flush) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        scan_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(n);
        if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
        scan_idx = scan_sum[IDX_W-1:0];
        if (slot_valid_reg[scan_idx] && (grant_cnt < NPORTS)) begin
          grant[scan_idx] = 1'b1;
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_cnt == CNT_W'(k)) begin
              port_vld[k] = 1'b1;
              port_idx[k] = scan_idx;
            end
          end
          last_idx  = scan_idx;
          grant_cnt = grant_cnt + 1'b1;
        end
      end
    end
  end

  assign rr_ptr_next = (last_idx == LAST) ? '0 : last_idx + 1'b1;

  // A slot being drained this cycle can be refilled on the same edge.
  assign req_ready = flush ? '0 : (~slot_valid_reg | grant);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid_reg <= '0;
      rr_ptr_reg     <= '0;
      cmp_valid_reg  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_pc_reg[i]   <= '0;
        slot_data_reg[i] <= '0;
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        cmp_pc_reg[k]   <= '0;
        cmp_data_reg[k] <= '0;
      end
    end else if (flush) begin
      slot_valid_reg <= '0;
      cmp_valid_reg  <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cmp_pc_reg[k]   <= '0;
        cmp_data_reg[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slot_valid_reg[i] <= 1'b1;
          slot_pc_reg[i]    <= req_pc_arr[i];
          slot_data_reg[i]  <= req_data_arr[i];
        end else if (grant[i]) begin
          slot_valid_reg[i] <= 1'b0;
        end
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        cmp_valid_reg[k] <= port_vld[k];
        cmp_pc_reg[k]    <= port_vld[k] ? slot_pc_reg[port_idx[k]]   : '0;
        cmp_data_reg[k]  <= port_vld[k] ? slot_data_reg[port_idx[k]] : '0;
      end
      if (|grant) rr_ptr_reg <= rr_ptr_next;
    end
  end

`ifdef CMPL_ARB_STAT_EN
  logic [15:0] conflict_cnt_reg;

  // A cycle counts when some held completion was left waiting, whether by port limit or hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt_reg <= '0;
    end else if (!flush && (|(slot_valid_reg & ~grant)) && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign arb_conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_cmpl_arbiter.sv
// Directed testbench for cmpl_arbiter: per-cycle expected port contents are queued as stimulus
// is driven and popped after each clock edge. Covers CMPL_ARB_STAT_EN when defined.
module tb_cmpl_arbiter;

  localparam int NR = 6;
  localparam int NP = 4;
  localparam int XL = 32;

  logic           clk;
  logic           rstn;
  logic           flush;
  logic           cmp_hold;
  logic [NR-1:0]  req_valid;
  logic [NR*XL-1:0] req_pc;
  logic [NR*XL-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [NP-1:0]  cmp_valid;
  logic [NP*XL-1:0] cmp_pc;
  logic [NP*XL-1:0] cmp_data;
`ifdef CMPL_ARB_STAT_EN
  logic [15:0]    arb_conflict_cnt;
`endif

  typedef struct packed {
    logic [NP-1:0]    v;
    logic [NP*XL-1:0] pc;
    logic [NP*XL-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  cmpl_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .XLEN(XL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .cmp_hold  (cmp_hold),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cmp_valid (cmp_valid),
    .cmp_pc    (cmp_pc),
    .cmp_data  (cmp_data)
`ifdef CMPL_ARB_STAT_EN
    ,
    .arb_conflict_cnt (arb_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [NP-1:0] v, input logic [NP*XL-1:0] pc,
                          input logic [NP*XL-1:0] data);
    exp_t e;
    e.v = v; e.pc = pc; e.data = data;
    exp_q.push_back(e);
  endtask

  // Wait for the next edge and compare the registered ports against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 128'(1), 128'(0));
    end else begin
      e = exp_q.pop_front();
      chk("cmp_valid", 128'(cmp_valid), 128'(e.v));
      chk("cmp_pc",    128'(cmp_pc),    128'(e.pc));
      chk("cmp_data",  128'(cmp_data),  128'(e.data));
    end
  endtask

  task automatic set_req(input int i, input logic [XL-1:0] pc, input logic [XL-1:0] d);
    req_valid[i]         = 1'b1;
    req_pc[i*XL +: XL]   = pc;
    req_data[i*XL +: XL] = d;
  endtask

  task automatic check_ready(input string tag, input logic [NR-1:0] expv);
    #1;
    chk(tag, 128'(req_ready), 128'(expv));
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    chk("rst_cmp_valid", 128'(cmp_valid), 128'(0));
    chk("rst_cmp_pc",    128'(cmp_pc),    128'(0));
    chk("rst_rr_ptr",    128'(dut.rr_ptr_reg), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(6'h3f));
    rstn = 1'b1;
  endtask

  localparam logic [NP*XL-1:0] Z = '0;

  initial begin
    n_cmp = 0; n_err = 0;
    rstn = 1'b0; flush = 1'b0; cmp_hold = 1'b0;
    req_valid = '0; req_pc = '0; req_data = '0;

    // Power-on reset held across the first edge
    @(posedge clk);
    #1;
    chk("reset_cmp_valid", 128'(cmp_valid), 128'(0));
    chk("reset_cmp_pc",    128'(cmp_pc),    128'(0));
    chk("reset_cmp_data",  128'(cmp_data),  128'(0));
    chk("reset_rr_ptr",    128'(dut.rr_ptr_reg), 128'(0));
    chk("reset_ready",     128'(req_ready), 128'(6'h3f));
    rstn = 1'b1;

    // Single request from unit 2
    set_req(2, 32'h40, 32'h11);
    push_exp(4'h0, Z, Z); tick();
    req_valid = '0;
    push_exp(4'h1, {96'h0, 32'h40}, {96'h0, 32'h11}); tick();
    chk("single_rr_ptr", 128'(dut.rr_ptr_reg), 128'(3));
    push_exp(4'h0, Z, Z); tick();

    // Reset mid-operation drops an accepted but not yet granted completion
    set_req(0, 32'h50, 32'h55);
    push_exp(4'h0, Z, Z); tick();
    req_valid = '0;
    pulse_reset();
    push_exp(4'h0, Z, Z); tick();

    // Oversubscription: all six units at once, rr_ptr=0
    for (int i = 0; i < NR; i++) set_req(i, 32'h1000 + 32'(i), 32'hA0 + 32'(i));
    push_exp(4'h0, Z, Z); tick();
    req_valid = '0;
    check_ready("oversub_ready_a", 6'b001111);
    push_exp(4'hf, {32'h1003, 32'h1002, 32'h1001, 32'h1000},
                   {32'hA3, 32'hA2, 32'hA1, 32'hA0}); tick();
    chk("oversub_rr_a", 128'(dut.rr_ptr_reg), 128'(4));
    check_ready("oversub_ready_b", 6'h3f);
    push_exp(4'h3, {64'h0, 32'h1005, 32'h1004}, {64'h0, 32'hA5, 32'hA4}); tick();
    chk("oversub_rr_wrap", 128'(dut.rr_ptr_reg), 128'(0));

    // Back-to-back stream from unit 1
    set_req(1, 32'h100, 32'hB0);
    check_ready("stream_ready_0", 6'h3f);
    push_exp(4'h0, Z, Z); tick();
    set_req(1, 32'h104, 32'hB4);
    check_ready("stream_ready_1", 6'h3f);
    push_exp(4'h1, {96'h0, 32'h100}, {96'h0, 32'hB0}); tick();
    set_req(1, 32'h108, 32'hB8);
    check_ready("stream_ready_2", 6'h3f);
    push_exp(4'h1, {96'h0, 32'h104}, {96'h0, 32'hB4}); tick();
    req_valid = '0;
    push_exp(4'h1, {96'h0, 32'h108}, {96'h0, 32'hB8}); tick();
    push_exp(4'h0, Z, Z); tick();
    chk("stream_rr", 128'(dut.rr_ptr_reg), 128'(2));

    // Hold with slots 0 and 3 occupied
    set_req(0, 32'h300, 32'hC0);
    set_req(3, 32'h330, 32'hC3);
    push_exp(4'h0, Z, Z); tick();
    req_valid = '0;
    cmp_hold  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_ready("hold_ready", 6'b110110);
      push_exp(4'h0, Z, Z); tick();
    end
    chk("hold_rr_frozen", 128'(dut.rr_ptr_reg), 128'(2));
    cmp_hold = 1'b0;
    push_exp(4'h3, {64'h0, 32'h300, 32'h330}, {64'h0, 32'hC0, 32'hC3}); tick();
    chk("release_rr", 128'(dut.rr_ptr_reg), 128'(1));
    push_exp(4'h0, Z, Z); tick();

    // Flush with three slots held and two ports valid
    set_req(0, 32'h500, 32'hD0);
    set_req(1, 32'h510, 32'hD1);
    push_exp(4'h0, Z, Z); tick();
    req_valid = '0;
    set_req(2, 32'h520, 32'hD2);
    set_req(3, 32'h530, 32'hD3);
    set_req(4, 32'h540, 32'hD4);
    push_exp(4'h3, {64'h0, 32'h500, 32'h510}, {64'h0, 32'hD0, 32'hD1}); tick();
    req_valid = '0;
    flush = 1'b1;
    set_req(5, 32'h550, 32'hD5);
    check_ready("flush_ready", 6'h00);
    push_exp(4'h0, Z, Z); tick();
    flush = 1'b0;
    req_valid = '0;
    check_ready("post_flush_ready", 6'h3f);
    chk("flush_rr_kept", 128'(dut.rr_ptr_reg), 128'(1));
    push_exp(4'h0, Z, Z); tick();
    push_exp(4'h0, Z, Z); tick();

`ifdef CMPL_ARB_STAT_EN
    // Conflict counter: five units, one deferred for a single cycle
    pulse_reset();
    chk("stat_reset", 128'(arb_conflict_cnt), 128'(0));
    for (int i = 0; i < 5; i++) set_req(i, 32'h600 + 32'(i), 32'hE0 + 32'(i));
    push_exp(4'h0, Z, Z); tick();
    chk("stat_after_accept", 128'(arb_conflict_cnt), 128'(0));
    req_valid = '0;
    push_exp(4'hf, {32'h603, 32'h602, 32'h601, 32'h600},
                   {32'hE3, 32'hE2, 32'hE1, 32'hE0}); tick();
    chk("stat_deferred", 128'(arb_conflict_cnt), 128'(1));
    push_exp(4'h1, {96'h0, 32'h604}, {96'h0, 32'hE4}); tick();
    chk("stat_drained", 128'(arb_conflict_cnt), 128'(1));
    push_exp(4'h0, Z, Z); tick();
    chk("stat_idle", 128'(arb_conflict_cnt), 128'(1));
`endif

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmpl_arbiter.md
Name: cmpl_arbiter

Overview:
- Completion-bus arbiter between the functional units (ALUs, LSU) and the reorder buffer's four completion ports.
- Each unit hands over a finished instruction as (PC, result) through a valid/ready handshake into a one-entry holding slot.
- Each cycle, a rotating-priority scheduler grants up to NUM_PORTS slots onto registered completion ports (cmp_pc_k / cmp_data_k), which feed the ROB's complete_pc / new_dr_data inputs.

Parameters:
- NUM_REQ, 6, number of requesting functional units (2..8).
- NUM_PORTS, 4, number of ROB completion ports (1..NUM_REQ).
- XLEN, 32, PC and data width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held and output completions.
- cmp_hold  in  1  ROB back-pressure; no grants while high.
- req_valid  in  NUM_REQ  per-unit completion valid.
- req_pc  in  NUM_REQ*XLEN  unit i PC at bits [i*XLEN +: XLEN].
- req_data  in  NUM_REQ*XLEN  unit i result, same packing.
- req_ready  out  NUM_REQ  slot i can accept this cycle.
- cmp_valid  out  NUM_PORTS  completion port k valid.
- cmp_pc  out  NUM_PORTS*XLEN  port k PC, 0 when invalid.
- cmp_data  out  NUM_PORTS*XLEN  port k data, 0 when invalid.

Behaviour:
- Clock and reset: single clock clk. rstn is asynchronous, active-low.
- Reset state: all holding slots empty, rr_ptr=0, and cmp_valid, cmp_pc and cmp_data all 0.
- req_ready[i]: !flush && (slot i empty || (slot i granted this cycle)). It is combinational from slot state, cmp_hold, flush and the grant vector. It never depends on req_valid.
- Accept: on a rising edge with req_valid[i] && req_ready[i], slot i captures pc/data and becomes valid.
- Arbitration (combinational, over valid slots):
  - Suppressed entirely when cmp_hold=1 or flush=1.
  - Otherwise scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ. The first NUM_PORTS valid slots found are granted.
  - The n-th granted slot in scan order drives port n. Ports are filled from 0 upward with no gaps.
- Output register: on each edge, port n loads the granted slot's pc/data with valid=1. Unused ports load valid=0, pc=0, data=0. A granted slot empties unless it is refilled by a simultaneous accept.
- Latency: accepted at edge t, the completion appears on a port after edge t+1 at the earliest. Each completion is presented for exactly one cycle. The ROB has no ready signal, so it must sample every cycle.
- rr_ptr update: if at least one grant, rr_ptr = (index of last granted slot + 1) mod NUM_REQ. Otherwise rr_ptr is unchanged. Wrap-around from NUM_REQ-1 to 0 is required.
- Fairness: no valid slot waits more than ceil(NUM_REQ/NUM_PORTS) grant cycles while cmp_hold=0.
- cmp_hold=1: slots retain their contents. Empty slots still accept new requests. Outputs load invalid/zero on the next edge. rr_ptr is frozen.
- flush=1 (highest priority after reset): next edge clears all slots and outputs and accepts nothing. rr_ptr is unchanged.
- Reset mid-operation: immediate return to the reset state, with all in-flight completions dropped.
- Duplicate PCs across units are not checked and are passed through as-is.
- Output ordering is by scan order only. Age order is not guaranteed.

Optional Feature:
- Macro: CMPL_ARB_STAT_EN.
- When defined:
  - Adds output port arb_conflict_cnt (16 bits).
  - Counts cycles in which at least one valid slot was not granted, whether from the port limit or from cmp_hold=1.
  - The counter saturates at 16'hFFFF, is cleared by rstn, and is not cleared by flush.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then a single request: unit 2 presents pc=0x40, data=0x11 at cycle 1 → cmp_valid=4'b0001, cmp_pc_0=0x40, cmp_data_0=0x11 for exactly one cycle after edge 2, then rr_ptr=3.
- Oversubscription: all 6 units valid simultaneously with rr_ptr=0 → cycle A grants units 0-3 on ports 0-3, cycle B grants units 4,5 on ports 0,1, and rr_ptr goes 4 then 0.
- Back-to-back throughput: unit 1 streams pc=0x100, 0x104, 0x108 with cmp_hold=0 → req_ready[1] stays 1 and port 0 shows one PC per cycle with no bubbles.
- Hold: slots 0 and 3 valid while cmp_hold=1 for 3 cycles → cmp_valid=0 throughout and req_ready[0]=req_ready[3]=0; after release both appear on the same cycle on ports 0 and 1.
- Flush: 3 slots valid and 2 ports valid when flush is pulsed → next cycle has all slots empty, cmp_valid=0, cmp_pc=0, and no acceptance during the flush cycle.
- With CMPL_ARB_STAT_EN defined and 5 units valid for 2 cycles → arb_conflict_cnt=1 after cycle 1 (unit 4 deferred) and stays 1 when all remaining work is granted.
